// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             g;
    logic             p;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, g, p
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, g, p
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined two-level (4-ary) carry-lookahead adder/subtractor with valid/ready flow control.
// STAGES selects 1, 2 or 3 register stages between the accepting edge and the result.
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    cla_pipe_addsub_if.slave bus
);
    localparam int NB  = WIDTH / 4;
    localparam int MSB = WIDTH - 1;

    function automatic logic [1:0] f_gp4(input logic [3:0] gi, input logic [3:0] pi);
        logic [1:0] r;
        r[1] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) |
               (pi[3] & pi[2] & pi[1] & gi[0]);
        r[0] = &pi;
        return r;
    endfunction

    function automatic logic [3:0] f_cin4(input logic [3:0] gi, input logic [3:0] pi,
                                          input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = gi[0] | (pi[0] & ci);
        c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) |
               (pi[2] & pi[1] & pi[0] & ci);
        return c;
    endfunction

    logic              w_adv;
    logic              w_acc;
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_ld;

    assign w_adv         = bus.out_ready || !r_vld[STAGES-1];
    assign w_acc         = bus.in_valid && w_adv;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[STAGES-1];

    // Data registers only load when a valid beat moves into them, so idle outputs hold.
    always_comb begin
        w_ld    = '0;
        w_ld[0] = w_adv && w_acc;
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_ld[i] = w_adv && r_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[0] <= w_acc;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    logic [WIDTH-1:0] w_bb;
    logic [WIDTH-1:0] w_bg;
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    logic [NB-1:0]    w_blk_g;
    logic [NB-1:0]    w_blk_p;

    always_comb begin
        w_bb    = bus.sub ? ~bus.b : bus.b;
        w_c0    = bus.sub ? ~bus.cin : bus.cin;
        w_bg    = bus.a & w_bb;
        w_bp    = bus.a ^ w_bb;
        w_blk_g = '0;
        w_blk_p = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            {w_blk_g[k], w_blk_p[k]} = f_gp4(w_bg[4*k +: 4], w_bp[4*k +: 4]);
        end
    end

    logic [WIDTH-1:0] w_s1_bg;
    logic [WIDTH-1:0] w_s1_bp;
    logic [NB-1:0]    w_s1_blk_g;
    logic [NB-1:0]    w_s1_blk_p;
    logic             w_s1_c0;
    logic             w_s1_sa;
    logic             w_s1_sb;

    if (STAGES >= 2) begin : g_reg1
        logic [WIDTH-1:0] r_bg;
        logic [WIDTH-1:0] r_bp;
        logic [NB-1:0]    r_blk_g;
        logic [NB-1:0]    r_blk_p;
        logic             r_c0;
        logic             r_sa;
        logic             r_sb;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_bg    <= '0;
                r_bp    <= '0;
                r_blk_g <= '0;
                r_blk_p <= '0;
                r_c0    <= 1'b0;
                r_sa    <= 1'b0;
                r_sb    <= 1'b0;
            end else if (w_ld[0]) begin
                r_bg    <= w_bg;
                r_bp    <= w_bp;
                r_blk_g <= w_blk_g;
                r_blk_p <= w_blk_p;
                r_c0    <= w_c0;
                r_sa    <= bus.a[MSB];
                r_sb    <= w_bb[MSB];
            end
        end

        assign w_s1_bg    = r_bg;
        assign w_s1_bp    = r_bp;
        assign w_s1_blk_g = r_blk_g;
        assign w_s1_blk_p = r_blk_p;
        assign w_s1_c0    = r_c0;
        assign w_s1_sa    = r_sa;
        assign w_s1_sb    = r_sb;
    end else begin : g_comb1
        assign w_s1_bg    = w_bg;
        assign w_s1_bp    = w_bp;
        assign w_s1_blk_g = w_blk_g;
        assign w_s1_blk_p = w_blk_p;
        assign w_s1_c0    = w_c0;
        assign w_s1_sa    = bus.a[MSB];
        assign w_s1_sb    = w_bb[MSB];
    end

    logic [3:0]       w_sg;
    logic [3:0]       w_sp;
    logic [3:0]       w_sc;
    logic             w_wg;
    logic             w_wp;
    logic             w_co;
    logic [WIDTH-1:0] w_cy;

    // Block G/P is padded to 16 entries with G=0/P=1 so the upper levels are a fixed
    // 4x4 tree; padding propagates, so word G/P and the carry-out are unchanged.
    always_comb begin
        logic [15:0] pg;
        logic [15:0] pp;
        logic [15:0] bc;
        pg = '0;
        pp = '1;
        bc = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            pg[k] = w_s1_blk_g[k];
            pp[k] = w_s1_blk_p[k];
        end
        w_sg = '0;
        w_sp = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            {w_sg[j], w_sp[j]} = f_gp4(pg[4*j +: 4], pp[4*j +: 4]);
        end
        {w_wg, w_wp} = f_gp4(w_sg, w_sp);
        w_co = w_wg | (w_wp & w_s1_c0);
        w_sc = f_cin4(w_sg, w_sp, w_s1_c0);
        for (int unsigned j = 0; j < 4; j++) begin
            bc[4*j +: 4] = f_cin4(pg[4*j +: 4], pp[4*j +: 4], w_sc[j]);
        end
        w_cy = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            w_cy[4*k +: 4] = f_cin4(w_s1_bg[4*k +: 4], w_s1_bp[4*k +: 4], bc[k]);
        end
    end

    logic [WIDTH-1:0] w_s2_bp;
    logic [WIDTH-1:0] w_s2_cy;
    logic             w_s2_co;
    logic             w_s2_wg;
    logic             w_s2_wp;
    logic             w_s2_sa;
    logic             w_s2_sb;

    if (STAGES == 3) begin : g_reg2
        logic [WIDTH-1:0] r_bp;
        logic [WIDTH-1:0] r_cy;
        logic             r_co;
        logic             r_wg;
        logic             r_wp;
        logic             r_sa;
        logic             r_sb;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_bp <= '0;
                r_cy <= '0;
                r_co <= 1'b0;
                r_wg <= 1'b0;
                r_wp <= 1'b0;
                r_sa <= 1'b0;
                r_sb <= 1'b0;
            end else if (w_ld[1]) begin
                r_bp <= w_s1_bp;
                r_cy <= w_cy;
                r_co <= w_co;
                r_wg <= w_wg;
                r_wp <= w_wp;
                r_sa <= w_s1_sa;
                r_sb <= w_s1_sb;
            end
        end

        assign w_s2_bp = r_bp;
        assign w_s2_cy = r_cy;
        assign w_s2_co = r_co;
        assign w_s2_wg = r_wg;
        assign w_s2_wp = r_wp;
        assign w_s2_sa = r_sa;
        assign w_s2_sb = r_sb;
    end else begin : g_comb2
        assign w_s2_bp = w_s1_bp;
        assign w_s2_cy = w_cy;
        assign w_s2_co = w_co;
        assign w_s2_wg = w_wg;
        assign w_s2_wp = w_wp;
        assign w_s2_sa = w_s1_sa;
        assign w_s2_sb = w_s1_sb;
    end

    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    assign w_sum = w_s2_bp ^ w_s2_cy;
    assign w_ovf = (w_s2_sa == w_s2_sb) && (w_sum[MSB] != w_s2_sa);

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_g;
    logic             r_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_g    <= 1'b0;
            r_p    <= 1'b0;
        end else if (w_ld[STAGES-1]) begin
            r_sum  <= w_sum;
            r_cout <= w_s2_co;
            r_ovf  <= w_ovf;
            r_g    <= w_s2_wg;
            r_p    <= w_s2_wp;
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.g    = r_g;
    assign bus.p    = r_p;
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's 4-bit-group, two-level CLA adders.
- Generalises width (WIDTH, multiple of 4) and pipeline depth (STAGES).
- Adds a subtract mode, signed-overflow flag, and valid/ready handshake with backpressure.
- Sits in datapath front ends feeding accumulators and comparators.

Parameters:
- WIDTH, 32, operand/result width; multiple of 4, range 8..64.
- STAGES, 2, register stages from accept to result; legal values 1, 2, 3.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In subtract mode this is the not-borrow.
- ovf  output  1  two's-complement overflow.
- g  output  1  word-level group generate of the effective operands.
- p  output  1  word-level group propagate of the effective operands.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - On reset: out_valid=0, sum=0, cout=0, ovf=0, g=0, p=0, and all internal stage-valid bits=0.
  - A beat accepted in the same cycle that reset is high is discarded.
  - Reset mid-operation flushes all in-flight beats. None is ever output.
- Arithmetic:
  - Effective operands: bb = sub ? ~b : b; c0 = sub ? ~cin : cin.
  - Result: {cout,sum} = a + bb + c0. With sub=1 this gives a - b - cin.
  - ovf = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
  - Carry structure: bit g/p, then 4-bit block lookahead cells, then further 4-ary lookahead levels over block G/P until one word-level G/P remains. Block carries are redistributed to the bits.
  - g and p are the top-level G and P. They are independent of c0.
  - Results must be bit-exact to the integer equation for all inputs.
- Pipeline partition (latency = STAGES cycles from accepting edge to out_valid=1):
  - STAGES=1: entire add computed combinationally; all outputs registered.
  - STAGES=2: stage 1 registers bit g/p/xor, block G/P, c0, and sign bits. Stage 2 does upper lookahead, carries, and sum, registered to the outputs.
  - STAGES=3: as STAGES=2, plus a register after the word-level carry computation, before the sum/ovf form.
- Handshake:
  - adv = out_ready || !out_valid.
  - in_ready = adv. This is combinational and has no dependency on in_valid.
  - Accept happens when in_valid && in_ready.
  - When adv=1, every stage shifts one place. A stage valid bit loads the valid bit of the stage before it; stage 0 loads in_valid && in_ready.
  - When adv=0, all stages hold. sum, cout, ovf, g, p and out_valid stay stable while out_valid && !out_ready.
  - Bubbles are not collapsed. Throughput is 1 beat/cycle when out_ready stays at 1.
  - A simultaneous accept and output handshake in the same cycle is legal: full throughput, no loss.
- Data-register policy:
  - Data registers load only when adv=1.
  - Outputs with out_valid=0 hold their last value; after reset they hold 0.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1, sub=0: a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 2 cycles out_valid=1, sum=0, cout=1, ovf=0, g=1, p=0.
- Subtract, any STAGES: a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Second beat a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Full-propagate carry chain: a=0xAAAAAAAA, b=0x55555555, cin=1 -> sum=0, cout=1, p=1, g=0. Same operands with cin=0 -> sum=0xFFFFFFFF, cout=0.
- Backpressure, STAGES=3: stream beats 1..8 with out_ready toggling in pattern 1,0,0,1,... -> outputs in order, none lost or duplicated, outputs stable while stalled, in_ready = out_ready || !out_valid every cycle.
- Reset mid-stream: reset asserted 1 cycle with 2 beats in flight -> next cycle out_valid=0 and all outputs 0. Neither flushed beat ever appears; the first beat accepted after reset emerges after STAGES cycles.
- Random self-check, 10k beats for each WIDTH in {8,32,64} and each STAGES in {1,2,3}, random handshakes -> every field matches the reference integer model.
